mp_add_seq: RTL and testbench
=============================

MP_ADD_SEQ -- requirements
Module: mp_add_seq

Interface
REQ-001 SHALL declare parameter NBYTES, default 4; number of 8-bit slices per operand (operand width W = 8*NBYTES).
REQ-002 SHALL declare port clk, input, 1 bit; single clock, all state updates on the rising edge.
REQ-003 SHALL declare port rst, input, 1 bit; synchronous, active-high reset.
REQ-004 SHALL declare port start, input, 1 bit; request to begin an addition, sampled only in IDLE.
REQ-005 SHALL declare port A, input, W bits; operand A, captured when start is accepted.
REQ-006 SHALL declare port B, input, W bits; operand B, captured when start is accepted.
REQ-007 SHALL declare port in_C, input, 1 bit; carry-in, captured when start is accepted.
REQ-008 SHALL declare port busy, output, 1 bit; high in RUN and DONE.
REQ-009 SHALL declare port done, output, 1 bit; one-cycle completion pulse.
REQ-010 SHALL declare port S, output, W bits; registered result.
REQ-011 SHALL declare port out_C, output, 1 bit; registered carry-out from the top slice.
REQ-012 SHALL declare port ovf, output, 1 bit; registered signed overflow.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 SHALL, in IDLE with start=1: latch A, B and in_C, set the slice index k=0, load the carry register with the initial carry, and move to RUN.
REQ-015 SHALL, in each RUN cycle: add byte k of A and B plus the carry register through one 8-bit slice, write the slice sum into byte k of the internal accumulator, store the slice carry-out in the carry register, and increment k.
REQ-016 SHALL move from RUN to DONE when k=NBYTES-1, so RUN lasts exactly NBYTES cycles.
REQ-017 SHALL, on the RUN->DONE edge, load S, out_C and ovf together; they hold that value until the next completed operation.
REQ-018 SHALL assert done only in DONE, for exactly one cycle, then return to IDLE.
REQ-019 Latency: a start accepted at edge t SHALL give done=1 in the cycle after edge t+NBYTES (NBYTES+1 cycles from start to done).
REQ-020 SHALL ignore start while busy=1; no queuing, and latched operands are not disturbed.
REQ-021 SHALL compute ovf = (A'[W-1] == B'[W-1]) && (S[W-1] != A'[W-1]), where A' and B' are the operands actually added.
REQ-022 SHALL produce full mod-2^W arithmetic: S = (A + B + cin) mod 2^W and out_C = bit W of the same sum.
REQ-023 SHALL propagate the carry across slice boundaries with no loss, including the all-ones chain (0xFFFFFFFF + 1).
REQ-024 Back-to-back operation: start held high SHALL be accepted in the IDLE cycle following DONE, giving a throughput of one operation per NBYTES+2 cycles.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, force the state to IDLE, k=0, carry register=0, busy=0, done=0, S=0, out_C=0 and ovf=0.
REQ-026 SHALL abandon any in-flight operation on reset, with no done pulse and no update to S.
REQ-027 SHALL give rst priority over start on the same edge.

Configuration
REQ-028 SHALL support macro MP_ADD_SUB_EN; when it is defined, add input port sub (1 bit, captured with the operands).
REQ-029 SHALL, with MP_ADD_SUB_EN defined and sub=1: use B' = ~B, set the initial carry to 1 (in_C ignored), and compute S = A - B mod 2^W; out_C=1 means no borrow.
REQ-030 SHALL, without MP_ADD_SUB_EN: have no sub port, B' = B, and initial carry = in_C.

Structure
REQ-031 Shared package mp_add_pkg SHALL hold the FSM state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the slice width constant SLICE_W=8.
REQ-032 SHALL instantiate one sub-module, cla8_slice: a combinational 8-bit carry-lookahead adder with ports A[7:0], B[7:0], in_C -> S[7:0], out_C; exactly one instance, time-shared across slices.

Verification
REQ-033 Reset, then A=0x000000FF, B=0x00000001, in_C=0 -> done in the 5th cycle after start, S=0x00000100, out_C=0, ovf=0.
REQ-034 A=0xFFFFFFFF, B=0x00000000, in_C=1 -> S=0x00000000, out_C=1, ovf=0 (full carry ripple across all slices).
REQ-035 A=0x7FFFFFFF, B=0x00000001, in_C=0 -> S=0x80000000, out_C=0, ovf=1.
REQ-036 start pulsed again at RUN cycle 2 with different operands -> ignored; first result unchanged; exactly one done pulse.
REQ-037 rst asserted in RUN cycle 3 -> next cycle busy=0, S=0, no done pulse; a subsequent start completes normally.
REQ-038 With MP_ADD_SUB_EN defined: sub=1, A=0x00000005, B=0x00000007 -> S=0xFFFFFFFE, out_C=0, ovf=0.

Source files
------------

// File: rtl/mp_add_pkg.sv
// Shared constants for the sequential multi-byte adder: FSM encoding and slice width.
package mp_add_pkg;

   localparam int SLICE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/cla8_slice.sv
// Combinational 8-bit carry-lookahead adder slice, time-shared by mp_add_seq.
module cla8_slice
   import mp_add_pkg::*;
(
   input  logic [SLICE_W-1:0] A,
   input  logic [SLICE_W-1:0] B,
   input  logic               in_C,
   output logic [SLICE_W-1:0] S,
   output logic               out_C
);

   logic [SLICE_W-1:0] p;
   logic [SLICE_W-1:0] g;
   logic [SLICE_W:0]   c;

   assign p = A ^ B;
   assign g = A & B;

   // Each carry is a flat sum of products of g/p terms and in_C, not a ripple chain.
   always_comb begin
      logic prop;
      c = '0;
      c[0] = in_C;
      for (int i = 1; i <= SLICE_W; i++) begin
         prop = 1'b1;
         for (int j = i - 1; j >= 0; j--) begin
            c[i] = c[i] | (prop & g[j]);
            prop = prop & p[j];
         end
         c[i] = c[i] | (prop & in_C);
      end
   end

   assign S     = p ^ c[SLICE_W-1:0];
   assign out_C = c[SLICE_W];

endmodule

// File: rtl/mp_add_seq.sv
// Sequential W-bit adder: one cla8_slice processes one byte per RUN cycle.
// Optional subtract mode is enabled by defining MP_ADD_SUB_EN (adds the sub port).
module mp_add_seq
   import mp_add_pkg::*;
#(
   parameter int NBYTES = 4
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [SLICE_W*NBYTES-1:0] A,
   input  logic [SLICE_W*NBYTES-1:0] B,
   input  logic                    in_C,
`ifdef MP_ADD_SUB_EN
   input  logic                    sub,
`endif
   output logic                    busy,
   output logic                    done,
   output logic [SLICE_W*NBYTES-1:0] S,
   output logic                    out_C,
   output logic                    ovf
);

   localparam int W  = SLICE_W * NBYTES;
   localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   state_t state, state_nx;

   logic [KW-1:0]      k;
   logic               carry;
   logic [W-1:0]       a_q, b_q, acc, acc_nx;
   logic [W-1:0]       b_eff;
   logic               cin_eff;
   logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
   logic               sl_c;
   logic               last;

`ifdef MP_ADD_SUB_EN
   assign b_eff   = sub ? ~B : B;
   assign cin_eff = sub ? 1'b1 : in_C;
`else
   assign b_eff   = B;
   assign cin_eff = in_C;
`endif

   assign sl_a = a_q[k*SLICE_W +: SLICE_W];
   assign sl_b = b_q[k*SLICE_W +: SLICE_W];
   assign last = (k == KW'(NBYTES - 1));

   cla8_slice u_slice (
      .A     (sl_a),
      .B     (sl_b),
      .in_C  (carry),
      .S     (sl_s),
      .out_C (sl_c)
   );

   // Accumulator with the current slice merged in, so the final byte reaches S on the same edge.
   always_comb begin
      acc_nx = acc;
      acc_nx[k*SLICE_W +: SLICE_W] = sl_s;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last)  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         k     <= '0;
         carry <= 1'b0;
         S     <= '0;
         out_C <= 1'b0;
         ovf   <= 1'b0;
      end else if (state == IDLE && start) begin
         k     <= '0;
         carry <= cin_eff;
      end else if (state == RUN) begin
         k     <= k + 1'b1;
         carry <= sl_c;
         if (last) begin
            S     <= acc_nx;
            out_C <= sl_c;
            ovf   <= (a_q[W-1] == b_q[W-1]) && (acc_nx[W-1] != a_q[W-1]);
         end
      end
   end

   // Operand and accumulator storage carries no reset; results only leave via S.
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         a_q <= A;
         b_q <= b_eff;
      end
      if (state == RUN) acc <= acc_nx;
   end

endmodule

// File: tb/tb_mp_add_seq.sv
// Randomized self-checking bench for mp_add_seq against an arithmetic reference model.
module tb_mp_add_seq;

   localparam int NBYTES = 4;
   localparam int W      = 8 * NBYTES;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] A, B;
   logic         in_C;
`ifdef MP_ADD_SUB_EN
   logic         sub;
`endif
   logic         busy, done;
   logic [W-1:0] S;
   logic         out_C, ovf;

   int n_chk  = 0;
   int n_fail = 0;

   mp_add_seq #(.NBYTES(NBYTES)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .in_C  (in_C),
`ifdef MP_ADD_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .S     (S),
      .out_C (out_C),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic; overflow is the signed sum leaving the W-bit range.
   function automatic void model(input logic [W-1:0] a, b, input logic cin, sb,
                                 output logic [W-1:0] s, output logic co, output logic ov);
      logic [W-1:0] bp;
      longint ua, ub, ci, sum, sa, sbv, ssum;
      bp   = sb ? ~b : b;
      ci   = sb ? 1 : longint'(cin);
      ua   = longint'(a);
      ub   = longint'(bp);
      sum  = ua + ub + ci;
      s    = sum[W-1:0];
      co   = sum[W];
      sa   = longint'($signed(a));
      sbv  = longint'($signed(bp));
      ssum = sa + sbv + ci;
      ov   = (ssum > (longint'(1) <<< (W-1)) - 1) || (ssum < -(longint'(1) <<< (W-1)));
   endfunction

   task automatic drive(input logic [W-1:0] a, b, input logic cin, sb);
      A    = a;
      B    = b;
      in_C = cin;
`ifdef MP_ADD_SUB_EN
      sub  = sb;
`endif
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!done && cyc < 20);
   endtask

   // One operation from IDLE; intrude>=0 pulses start with other operands at that RUN cycle.
   task automatic run_op(input logic [W-1:0] a, b, input logic cin, sb, input int intrude);
      logic [W-1:0] es;
      logic         ec, eo;
      int           cyc, dones;
      model(a, b, cin, sb, es, ec, eo);
      drive(a, b, cin, sb);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc   = 0;
      dones = 0;
      while (cyc < 20 && dones == 0) begin
         if (cyc == intrude) begin
            start = 1'b1;
            drive(~a, a ^ b, ~cin, 1'b0);
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
         if (done) dones++;
      end
      start = 1'b0;
      chk("latency", 64'(cyc), 64'(NBYTES));
      chk("S", 64'(S), 64'(es));
      chk("out_C", 64'(out_C), 64'(ec));
      chk("ovf", 64'(ovf), 64'(eo));
      chk("busy_done", 64'(busy), 64'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      chk("done_count", 64'(dones), 64'd1);
      chk("idle_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      int           cyc, dones;
      logic [W-1:0] ra, rb, es;
      logic         ec, eo;
      logic         rsub;

      rst   = 1'b1;
      start = 1'b0;
      drive('0, '0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_S", 64'(S), 64'd0);
      chk("rst_out_C", 64'(out_C), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);

      // Reset outranks start on the same edge.
      start = 1'b1;
      drive(32'h1234_5678, 32'h1, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("rst_prio_busy", 64'(busy), 64'd0);
      rst   = 1'b0;
      start = 1'b0;
      @(posedge clk); #1;

      run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, -1);
      run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, -1);
      run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, -1);
      run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, -1);
      run_op(32'h1357_9BDF, 32'h2468_ACE0, 1'b1, 1'b0, 2);

      // Reset during RUN cycle 3 abandons the operation.
      drive(32'hDEAD_BEEF, 32'h0101_0101, 1'b1, 1'b0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_S", 64'(S), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      chk("midrst_no_done", 64'(dones), 64'd0);
      run_op(32'hCAFE_F00D, 32'h1111_2222, 1'b0, 1'b0, -1);

      // Start held high: next op accepted in the IDLE cycle after DONE.
      drive(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1'b0);
      start = 1'b1;
      @(posedge clk); #1;
      wait_done(cyc);
      chk("b2b_lat1", 64'(cyc), 64'(NBYTES));
      model(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1'b0, es, ec, eo);
      chk("b2b_S1", 64'({out_C, S}), 64'({ec, es}));
      drive(32'h8000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk("b2b_idle", 64'(busy), 64'd0);
      @(posedge clk); #1;
      chk("b2b_accept", 64'(busy), 64'd1);
      start = 1'b0;
      wait_done(cyc);
      chk("b2b_lat2", 64'(cyc), 64'(NBYTES));
      model(32'h8000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, es, ec, eo);
      chk("b2b_S2", 64'({ovf, out_C, S}), 64'({eo, ec, es}));
      @(posedge clk); #1;

`ifdef MP_ADD_SUB_EN
      run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, -1);
      run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, -1);
`endif

      for (int n = 0; n < 24; n++) begin
         case ($urandom_range(0, 3))
            0:       ra = 32'hFFFF_FFFF;
            1:       ra = 32'h7FFF_FFFF;
            default: ra = $urandom;
         endcase
         rb = ($urandom_range(0, 3) == 0) ? 32'(n) : $urandom;
`ifdef MP_ADD_SUB_EN
         rsub = 1'($urandom_range(0, 1));
`else
         rsub = 1'b0;
`endif
         run_op(ra, rb, 1'($urandom_range(0, 1)), rsub, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
